prio_enc_disp: RTL and testbench
================================

# prio_enc_disp

Parametrised, debounced priority encoder with 7-segment readout, the next generation of the board's switch-to-LED encoder. It synchronises and debounces an N-bit switch vector, encodes the highest set bit, and holds the result in registered outputs. The block adds a freeze (`hold`) mode, a one-cycle change strobe and a hex display drive. It sits between the board switch/button pins and the LED/7-seg outputs of the top-level board wrapper.

## Interface
- `N`, default 8: switch vector width; legal range 2..16.
- `W`, default `$clog2(N)`: index width; derived, do not override.
- `STABLE_CYCLES`, default 4: consecutive identical samples required before a commit; legal range ≥1.
- `clk`, input, 1: sole clock.
- `rst`, input, 1: reset, asynchronous and active-low.
- `sw`, input, N: raw asynchronous switch vector.
- `hold`, input, 1: raw asynchronous freeze request; 1 freezes outputs.
- `idx`, output, W: index of the highest set bit of the committed vector.
- `valid`, output, 1: committed vector is non-zero.
- `changed`, output, 1: one-cycle pulse when `{valid,idx}` changes.
- `seg`, output, 8: active-low `{dp,g,f,e,d,c,b,a}`; hex digit of `idx`; all 1s when `valid`=0; `dp` is always 1 (off).

## Operation
- `sw` and `hold` each pass through a two-flop synchroniser, giving `sw_s` and `hold_s`.
- Debounce uses a candidate register `cand[N-1:0]` and a counter `cnt`, width `$clog2(STABLE_CYCLES)+1`:
  - If `sw_s` != `cand`: load `cand` with `sw_s` and clear `cnt` to 0.
  - Otherwise, if `cnt` < `STABLE_CYCLES-1`: increment `cnt`.
  - Otherwise: `cnt` saturates.
- A commit happens when `cnt` == `STABLE_CYCLES-1`, `sw_s` == `cand`, `hold_s` = 0 and `cand` != `committed`. On a commit:
  - `committed` is loaded with `cand`.
  - `idx`, `valid` and `seg` are loaded from the encode of `cand`.
- Encode: the highest set bit wins. An all-zero vector gives `idx`=0 and `valid`=0.
- `changed` is 1 in the cycle after a commit edge, and only when the new `{valid,idx}` differs from the old value. A vector change that leaves the encoded result unchanged (e.g. 0x26→0x24) commits silently.
- While `hold_s`=1, no commit occurs, but debouncing continues. When `hold_s` falls with a stable `cand` (`cnt` saturated) that differs from `committed`, the commit happens at the next edge.
- Reset values: `idx`=0, `valid`=0, `changed`=0, `seg`=8'hFF. Synchroniser flops, `cand`, `cnt` and `committed` are all 0.
- Reset asserted mid-debounce discards all progress; no commit follows reset release until a full debounce interval has elapsed.

## Timing
- A `sw` change that is stable from before edge 0 produces this sequence:
  - Edge 1: first synchroniser flop captures it.
  - Edge 2: `sw_s` shows it.
  - Edge 3: `cand` loads it, `cnt`=0.
  - Edge 3+`STABLE_CYCLES`: commit.
- Outputs therefore change `STABLE_CYCLES`+3 cycles after the input change (7 at the default).
- `changed` is high for exactly the one cycle following the commit edge.
- A `hold` deassertion with a saturated, differing `cand` commits 3 edges after the `hold` change.
- Any `sw_s` change during debouncing restarts the interval; the latency is measured from the last change.
- All outputs are registered; there is no combinational path from input to output.

## Structure
- Package `prio_enc_pkg` holds:
  - the 16-entry active-low 7-seg pattern constant array (0–F);
  - the `SEG_BLANK` = 8'hFF constant;
  - a function giving the index width from N.
- Sub-module `prio_enc`: purely combinational N→W priority encoder with a `valid` output, parametrised on N, implemented as a downward scan with no early loop exit.
- Top module: synchronisers, debounce counter, commit/hold logic, output registers and segment lookup.

## Test plan
All scenarios use N=8, `STABLE_CYCLES`=4.
1. Release reset with `sw`=0 → `idx`=0, `valid`=0, `seg`=8'hFF, `changed`=0, held indefinitely.
2. `sw`=8'h26 applied → exactly 7 cycles later `idx`=5, `valid`=1, `seg`=8'h92; `changed` high for one cycle.
3. Bit 7 toggled every 2 cycles for 20 cycles, then settled at 8'h80 → no commit while toggling; `idx`=7 exactly 7 cycles after the last toggle; a single `changed` pulse.
4. With `idx`=5 committed, raise `hold`, set `sw`=8'h01 and wait 20 cycles → `idx` stays 5. Drop `hold` → 3 cycles later `idx`=0, `valid`=1, one `changed` pulse.
5. Two steps:
   - `sw` 8'h26→8'h24 → no `changed` pulse, `idx` stays 5.
   - then `sw`=0 → 7 cycles later `valid`=0, `seg`=8'hFF, one `changed` pulse.
6. Pull `rst` low 4 cycles after `sw`=8'h10 is applied → outputs are at reset values immediately. Release reset while `sw` is held → commit of `idx`=4 occurs 7 cycles after release, not earlier.

Source files
------------

// File: rtl/prio_enc_pkg.sv
// Shared constants for the debounced priority encoder: 7-seg patterns and index width helper.
package prio_enc_pkg;

   localparam logic [7:0] SEG_BLANK = 8'hFF;

   // Active-low {dp,g,f,e,d,c,b,a} patterns for hex digits 0..F, dp always off.
   localparam logic [7:0] SEG_HEX [16] = '{
      8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
      8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
   };

   function automatic int unsigned idx_width(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/prio_enc.sv
// Combinational N-to-W priority encoder; highest set bit wins, all-zero gives idx 0 / invalid.
module prio_enc
   import prio_enc_pkg::*;
#(
   parameter int unsigned N = 8,
   parameter int unsigned W = idx_width(N)
) (
   input  logic [N-1:0] vec,
   output logic [W-1:0] idx_c,
   output logic         valid_c
);

   logic found;

   // Downward scan; the found flag masks lower bits instead of breaking out of the loop.
   always_comb begin
      idx_c = '0;
      found = 1'b0;
      for (int i = int'(N) - 1; i >= 0; i--) begin
         if (!found && vec[i]) begin
            idx_c = W'(i);
            found = 1'b1;
         end
      end
      valid_c = found;
   end

endmodule

// File: rtl/prio_enc_disp.sv
// Synchronised, debounced switch priority encoder with hold, change strobe and 7-seg drive.
module prio_enc_disp
   import prio_enc_pkg::*;
#(
   parameter int unsigned N             = 8,
   parameter int unsigned W             = idx_width(N),
   parameter int unsigned STABLE_CYCLES = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] sw,
   input  logic         hold,
   output logic [W-1:0] idx,
   output logic         valid,
   output logic         changed,
   output logic [7:0]   seg
);

   localparam int unsigned   CW      = $clog2(STABLE_CYCLES) + 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

   logic [N-1:0]  sw_m, sw_s;
   logic          hold_m, hold_s;
   logic [N-1:0]  cand, committed;
   logic [CW-1:0] cnt;
   logic [W-1:0]  enc_idx;
   logic          enc_valid;
   logic          commit_c;

   prio_enc #(.N(N), .W(W)) u_enc (
      .vec     (cand),
      .idx_c   (enc_idx),
      .valid_c (enc_valid)
   );

   // Candidate held long enough, input still agrees, not frozen, and actually new.
   assign commit_c = (cnt == CNT_MAX) && (sw_s == cand) && !hold_s && (cand != committed);

   // Two-flop synchronisers for the asynchronous pins.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sw_m   <= '0;
         sw_s   <= '0;
         hold_m <= 1'b0;
         hold_s <= 1'b0;
      end else begin
         sw_m   <= sw;
         sw_s   <= sw_m;
         hold_m <= hold;
         hold_s <= hold_m;
      end
   end

   // Debounce: any disagreement reloads the candidate and restarts the count.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cand <= '0;
         cnt  <= '0;
      end else if (sw_s != cand) begin
         cand <= sw_s;
         cnt  <= '0;
      end else if (cnt < CNT_MAX) begin
         cnt <= cnt + CW'(1);
      end
   end

   // Committed vector and registered outputs; strobe only when the encoded result moves.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         committed <= '0;
         idx       <= '0;
         valid     <= 1'b0;
         changed   <= 1'b0;
         seg       <= SEG_BLANK;
      end else begin
         changed <= 1'b0;
         if (commit_c) begin
            committed <= cand;
            idx       <= enc_idx;
            valid     <= enc_valid;
            seg       <= enc_valid ? SEG_HEX[4'(enc_idx)] : SEG_BLANK;
            changed   <= {enc_valid, enc_idx} != {valid, idx};
         end
      end
   end

endmodule

// File: tb/tb_prio_enc_disp.sv
// Bench for prio_enc_disp: directed timing scenarios plus randomized run against a run-length model.
module tb_prio_enc_disp;

   localparam int unsigned N = 8;
   localparam int unsigned S = 4;

   logic       clk;
   logic       rst;
   logic [7:0] sw;
   logic       hold;
   logic [2:0] idx;
   logic       valid;
   logic       changed;
   logic [7:0] seg;

   int total_cnt = 0;
   int pass_cnt  = 0;

   prio_enc_disp #(.N(N), .STABLE_CYCLES(S)) dut (
      .clk     (clk),
      .rst     (rst),
      .sw      (sw),
      .hold    (hold),
      .idx     (idx),
      .valid   (valid),
      .changed (changed),
      .seg     (seg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   localparam logic [7:0] HEX [8] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8};

   function automatic logic [2:0] ref_idx(input logic [7:0] v);
      ref_idx = 3'd0;
      for (int i = 0; i < 8; i++)
         if (v[i]) ref_idx = 3'(i);
   endfunction

   function automatic logic [7:0] ref_seg(input logic [7:0] v);
      logic [2:0] k;
      k = ref_idx(v);
      ref_seg = (v == 8'h00) ? 8'hFF : HEX[k];
   endfunction

   // Reference: a raw sample reaches the decision point two edges late; a value commits once
   // it has been seen S+1 times in a row (reset counts as one sighting of zero).
   logic [7:0] m_q1, m_q2, m_last, m_comm;
   logic       mh1, mh2;
   int         m_run;
   logic [2:0] m_idx;
   logic       m_valid, m_changed;
   logic [7:0] m_seg;
   logic       m_commit;

   assign m_commit = (m_q2 == m_last) && (m_run >= int'(S)) && !mh2 && (m_last != m_comm);

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_q1 <= '0; m_q2 <= '0; mh1 <= 1'b0; mh2 <= 1'b0;
         m_last <= '0; m_run <= 1; m_comm <= '0;
         m_idx <= '0; m_valid <= 1'b0; m_changed <= 1'b0; m_seg <= 8'hFF;
      end else begin
         m_q1 <= sw; m_q2 <= m_q1; mh1 <= hold; mh2 <= mh1;
         if (m_q2 != m_last) begin
            m_last <= m_q2;
            m_run  <= 1;
         end else if (m_run < int'(S)) begin
            m_run <= m_run + 1;
         end
         m_changed <= 1'b0;
         if (m_commit) begin
            m_comm    <= m_last;
            m_idx     <= ref_idx(m_last);
            m_valid   <= (m_last != 8'h00);
            m_seg     <= ref_seg(m_last);
            m_changed <= (ref_idx(m_last) != m_idx) || ((m_last != 8'h00) != m_valid);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      sw = 8'h00; hold = 1'b0; rst = 1'b0;
      tick(); tick();
      rst = 1'b1;
      for (int c = 0; c < 12; c++) begin
         tick();
         total_cnt++;
         if ({idx, valid, changed, seg} !== {3'd0, 1'b0, 1'b0, 8'hFF})
            $display("FAIL reset_idle c=%0d got idx=%0d v=%0b ch=%0b seg=%h want 0/0/0/ff",
                     c, idx, valid, changed, seg);
         else pass_cnt++;
      end
   endtask

   task automatic test_basic();
      logic [13:0] exp;
      sw = 8'h26;
      for (int c = 1; c <= 9; c++) begin
         tick();
         if (c < 7)       exp = {3'd0, 1'b0, 1'b0, 8'hFF};
         else if (c == 7) exp = {3'd5, 1'b1, 1'b1, 8'h92};
         else             exp = {3'd5, 1'b1, 1'b0, 8'h92};
         total_cnt++;
         if ({idx, valid, changed, seg} !== exp)
            $display("FAIL basic_0x26 c=%0d got %h want %h", c, {idx, valid, changed, seg}, exp);
         else pass_cnt++;
      end
   endtask

   task automatic test_bounce();
      int pulses = 0;
      for (int t = 0; t < 10; t++) begin
         sw = sw ^ 8'h80;
         for (int k = 0; k < 2; k++) begin
            tick();
            total_cnt++;
            if ({idx, changed} !== {3'd5, 1'b0})
               $display("FAIL bounce_toggling got idx=%0d ch=%0b want idx=5 ch=0", idx, changed);
            else pass_cnt++;
         end
      end
      sw = 8'h80;
      for (int c = 1; c <= 10; c++) begin
         tick();
         if (changed) pulses++;
         if (c == 6 || c == 7) begin
            total_cnt++;
            if (idx !== ((c == 7) ? 3'd7 : 3'd5))
               $display("FAIL bounce_settle c=%0d got idx=%0d want %0d", c, idx, (c == 7) ? 7 : 5);
            else pass_cnt++;
         end
      end
      total_cnt++;
      if (pulses !== 1) $display("FAIL bounce_pulses got %0d want 1", pulses);
      else pass_cnt++;
   endtask

   task automatic test_hold();
      int pulses = 0;
      sw = 8'h26;
      for (int c = 0; c < 10; c++) tick();
      hold = 1'b1;
      sw   = 8'h01;
      for (int c = 0; c < 20; c++) begin
         tick();
         total_cnt++;
         if ({idx, valid, changed} !== {3'd5, 1'b1, 1'b0})
            $display("FAIL hold_frozen c=%0d got idx=%0d v=%0b ch=%0b want 5/1/0", c, idx, valid, changed);
         else pass_cnt++;
      end
      hold = 1'b0;
      for (int c = 1; c <= 6; c++) begin
         tick();
         if (changed) pulses++;
         if (c == 2 || c == 3) begin
            total_cnt++;
            if ({idx, valid, seg} !== ((c == 3) ? {3'd0, 1'b1, 8'hC0} : {3'd5, 1'b1, 8'h92}))
               $display("FAIL hold_release c=%0d got idx=%0d v=%0b seg=%h", c, idx, valid, seg);
            else pass_cnt++;
         end
      end
      total_cnt++;
      if (pulses !== 1) $display("FAIL hold_pulses got %0d want 1", pulses);
      else pass_cnt++;
   endtask

   task automatic test_silent();
      logic [13:0] exp;
      sw = 8'h26;
      for (int c = 0; c < 10; c++) tick();
      sw = 8'h24;
      for (int c = 0; c < 12; c++) begin
         tick();
         total_cnt++;
         if ({idx, valid, changed} !== {3'd5, 1'b1, 1'b0})
            $display("FAIL silent_0x24 c=%0d got idx=%0d v=%0b ch=%0b want 5/1/0", c, idx, valid, changed);
         else pass_cnt++;
      end
      sw = 8'h00;
      for (int c = 1; c <= 8; c++) begin
         tick();
         if (c < 7)       exp = {3'd5, 1'b1, 1'b0, 8'h92};
         else if (c == 7) exp = {3'd0, 1'b0, 1'b1, 8'hFF};
         else             exp = {3'd0, 1'b0, 1'b0, 8'hFF};
         total_cnt++;
         if ({idx, valid, changed, seg} !== exp)
            $display("FAIL silent_to_zero c=%0d got %h want %h", c, {idx, valid, changed, seg}, exp);
         else pass_cnt++;
      end
   endtask

   task automatic test_reset_mid();
      logic [13:0] exp;
      sw = 8'h26;
      for (int c = 0; c < 10; c++) tick();
      sw = 8'h10;
      for (int c = 0; c < 4; c++) tick();
      rst = 1'b0;
      #1;
      total_cnt++;
      if ({idx, valid, changed, seg} !== {3'd0, 1'b0, 1'b0, 8'hFF})
         $display("FAIL reset_async got %h want 00ff", {idx, valid, changed, seg});
      else pass_cnt++;
      tick(); tick();
      rst = 1'b1;
      for (int c = 1; c <= 8; c++) begin
         tick();
         if (c < 7)       exp = {3'd0, 1'b0, 1'b0, 8'hFF};
         else if (c == 7) exp = {3'd4, 1'b1, 1'b1, 8'h99};
         else             exp = {3'd4, 1'b1, 1'b0, 8'h99};
         total_cnt++;
         if ({idx, valid, changed, seg} !== exp)
            $display("FAIL reset_release c=%0d got %h want %h", c, {idx, valid, changed, seg}, exp);
         else pass_cnt++;
      end
   endtask

   task automatic test_random();
      int dwell = 0;
      for (int c = 0; c < 1500; c++) begin
         if (dwell == 0) begin
            case ($urandom_range(0, 3))
               0:       sw = 8'($urandom_range(0, 255));
               1:       sw = sw ^ 8'(1 << $urandom_range(0, 7));
               2:       sw = 8'h00;
               default: sw = sw;
            endcase
            dwell = $urandom_range(1, 9);
         end
         dwell--;
         if ($urandom_range(0, 15) == 0) hold = ~hold;
         tick();
         total_cnt++;
         if ({idx, valid, changed, seg} !== {m_idx, m_valid, m_changed, m_seg})
            $display("FAIL random_vs_model c=%0d got %h want %h", c,
                     {idx, valid, changed, seg}, {m_idx, m_valid, m_changed, m_seg});
         else pass_cnt++;
      end
      hold = 1'b0;
   endtask

   initial begin
      rst = 1'b0; sw = 8'h00; hold = 1'b0;
      test_reset();
      test_basic();
      test_bounce();
      test_hold();
      test_silent();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
